p_nand_reg: RTL and testbench

- Parameterised multi-input bitwise NAND with a registered output.
- Combines NB_INS input buses of BUS_WIDTH bits; each output bit is the NAND of the same bit position across all inputs.
- General-purpose boolean primitive in the CPU datapath (ALU/flag logic). One clock, synchronous active-high reset, one-cycle latency, valid-qualified.

---
 rtl/p_nand_reg.sv | 68 ++++++
 tb/tb_p_nand_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/p_nand_reg.sv
// ---------------------------------------------------------------------------
// p_nand_reg
//
// Parameterised multi-input bitwise NAND with a registered, valid-qualified
// output. NB_INS buses of BUS_WIDTH bits are combined so that each output bit
// is the NAND of the same bit position across every input bus. The result is
// registered with one cycle of latency.
//
// Parameters:
//   BUS_WIDTH  width of each input bus and of the output bus (>= 1)
//   NB_INS     number of input buses combined (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; has priority over in_valid
//   in_valid   in_buses is evaluated and registered on this edge
//   in_buses   flattened buses, bus k = in_buses[k*BUS_WIDTH +: BUS_WIDTH]
//   out_valid  out_bus holds a result produced from a valid input
//   out_bus    registered NAND result; holds its value while idle
// ---------------------------------------------------------------------------
module p_nand_reg #(
    parameter int BUS_WIDTH = 4,
    parameter int NB_INS    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [NB_INS*BUS_WIDTH-1:0] in_buses,
    output logic                        out_valid,
    output logic [BUS_WIDTH-1:0]        out_bus
);

    // Reject degenerate sizes at elaboration rather than building a
    // zero-width datapath.
    generate
        if (BUS_WIDTH < 1 || NB_INS < 1) begin : g_bad_params
            $error("p_nand_reg: BUS_WIDTH and NB_INS must both be >= 1");
        end
    endgenerate

    logic [BUS_WIDTH-1:0] and_acc;
    logic [BUS_WIDTH-1:0] nand_res;

    // Linear AND accumulation over the buses, so any NB_INS works (not only
    // powers of two). With NB_INS = 1 this reduces to a plain bitwise NOT.
    always_comb begin
        and_acc = '1;
        for (int k = 0; k < NB_INS; k++) begin
            and_acc = and_acc & in_buses[k*BUS_WIDTH +: BUS_WIDTH];
        end
        nand_res = ~and_acc;
    end

    // Output register: reset wins over a simultaneous valid input, and the
    // data register only loads on valid so it holds the last result when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bus   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_bus <= nand_res;
            end
        end
    end

endmodule

// File: tb/tb_p_nand_reg.sv
// ---------------------------------------------------------------------------
// tb_p_nand_reg
//
// Self-checking bench for p_nand_reg. Two instances share clock and reset:
// the default 4-bit x 3-input configuration and a degenerate 8-bit x 1-input
// configuration. Expected results are pushed into a queue when stimulus is
// driven and popped for comparison once the output register has updated.
// ---------------------------------------------------------------------------
module tb_p_nand_reg;

    typedef struct {
        string      tag;
        logic [7:0] bus;
        logic       valid;
    } exp_t;

    logic        clk;
    logic        rst;

    // Default configuration: BUS_WIDTH = 4, NB_INS = 3
    logic        a_in_valid;
    logic [11:0] a_in_buses;
    logic        a_out_valid;
    logic [3:0]  a_out_bus;

    // Degenerate configuration: BUS_WIDTH = 8, NB_INS = 1
    logic        b_in_valid;
    logic [7:0]  b_in_buses;
    logic        b_out_valid;
    logic [7:0]  b_out_bus;

    exp_t        a_queue[$];
    exp_t        b_queue[$];

    logic [3:0]  a_model_bus;
    logic [7:0]  b_model_bus;

    int          num_checks;
    int          num_fails;

    p_nand_reg #(.BUS_WIDTH(4), .NB_INS(3)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_buses  (a_in_buses),
        .out_valid (a_out_valid),
        .out_bus   (a_out_bus)
    );

    p_nand_reg #(.BUS_WIDTH(8), .NB_INS(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_buses  (b_in_buses),
        .out_valid (b_out_valid),
        .out_bus   (b_out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Bit-by-bit reference for the 3-input NAND, written independently of
    // the accumulation style used in the design.
    function automatic logic [3:0] modelNand3(input logic [11:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = !(b[i] && b[4+i] && b[8+i]);
        end
        return r;
    endfunction

    // Pop the oldest expectation for each instance and compare it against
    // the registered outputs.
    task automatic drainQueues();
        exp_t e;
        if (a_queue.size() > 0) begin
            e = a_queue.pop_front();
            checkOutput({e.tag, "_a_bus"}, {28'd0, a_out_bus}, {28'd0, e.bus[3:0]});
            checkOutput({e.tag, "_a_valid"}, {31'd0, a_out_valid}, {31'd0, e.valid});
        end
        if (b_queue.size() > 0) begin
            e = b_queue.pop_front();
            checkOutput({e.tag, "_b_bus"}, {24'd0, b_out_bus}, {24'd0, e.bus});
            checkOutput({e.tag, "_b_valid"}, {31'd0, b_out_valid}, {31'd0, e.valid});
        end
    endtask

    // Drive one cycle on instance A with an explicit expected result, then
    // sample one time unit after the rising edge.
    task automatic applyStimulus(input string tag, input logic r, input logic v,
                                 input logic [11:0] buses,
                                 input logic [3:0] exp_bus, input logic exp_valid);
        exp_t e;
        @(negedge clk);
        rst        = r;
        a_in_valid = v;
        a_in_buses = buses;
        b_in_valid = 1'b0;
        e.tag   = tag;
        e.bus   = {4'd0, exp_bus};
        e.valid = exp_valid;
        a_queue.push_back(e);
        a_model_bus = exp_bus;
        @(posedge clk);
        #1;
        drainQueues();
    endtask

    // Drive one cycle on instance A with the expectation taken from the
    // behavioural model (used for the randomised section).
    task automatic applyModelStimulus(input logic r, input logic v,
                                      input logic [11:0] buses);
        logic [3:0] exp_bus;
        logic       exp_valid;
        if (r) begin
            exp_bus   = 4'd0;
            exp_valid = 1'b0;
        end else if (v) begin
            exp_bus   = modelNand3(buses);
            exp_valid = 1'b1;
        end else begin
            exp_bus   = a_model_bus;
            exp_valid = 1'b0;
        end
        applyStimulus("rand", r, v, buses, exp_bus, exp_valid);
    endtask

    // Drive one cycle on instance B (8-bit, single input = bitwise NOT).
    task automatic applyStimulusWide(input string tag, input logic v,
                                     input logic [7:0] bus0);
        exp_t e;
        @(negedge clk);
        rst        = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = v;
        b_in_buses = bus0;
        e.tag   = tag;
        e.bus   = v ? ~bus0 : b_model_bus;
        e.valid = v;
        b_queue.push_back(e);
        b_model_bus = e.bus;
        @(posedge clk);
        #1;
        drainQueues();
    endtask

    initial begin
        num_checks  = 0;
        num_fails   = 0;
        rst         = 1'b1;
        a_in_valid  = 1'b1;
        a_in_buses  = 12'hA5C;
        b_in_valid  = 1'b0;
        b_in_buses  = 8'h00;
        a_model_bus = 4'd0;
        b_model_bus = 8'd0;

        $display("[TB] Starting p_nand_reg test");

        // Reset held two cycles with valid data present: data is dropped.
        applyStimulus("reset0", 1'b1, 1'b1, 12'h3C7, 4'b0000, 1'b0);
        applyStimulus("reset1", 1'b1, 1'b1, 12'hFFF, 4'b0000, 1'b0);

        // Nominal: bus0=1101, bus1=1011, bus2=1111 -> 0110
        applyStimulus("nominal", 1'b0, 1'b1, {4'b1111, 4'b1011, 4'b1101}, 4'b0110, 1'b1);

        // Idle cycles with changing data: result holds, valid drops.
        applyStimulus("hold0", 1'b0, 1'b0, 12'h000, 4'b0110, 1'b0);
        applyStimulus("hold1", 1'b0, 1'b0, 12'h5A3, 4'b0110, 1'b0);

        // Extremes back-to-back.
        applyStimulus("all_ones", 1'b0, 1'b1, {4'b1111, 4'b1111, 4'b1111}, 4'b0000, 1'b1);
        applyStimulus("one_zero", 1'b0, 1'b1, {4'b1111, 4'b1111, 4'b0000}, 4'b1111, 1'b1);

        // Reset colliding with a valid input, then normal processing resumes.
        applyStimulus("rst_coll", 1'b1, 1'b1, {4'b1111, 4'b1011, 4'b1101}, 4'b0000, 1'b0);
        applyStimulus("after_rst", 1'b0, 1'b1, {4'b1111, 4'b1011, 4'b1101}, 4'b0110, 1'b1);

        // Zero in a middle bus only affects its own bit positions.
        applyStimulus("mid_bus", 1'b0, 1'b1, {4'b1111, 4'b0101, 4'b1111}, 4'b1010, 1'b1);

        // Randomised traffic with occasional idle and reset cycles.
        for (int n = 0; n < 40; n++) begin
            applyModelStimulus(($urandom_range(0, 15) == 0),
                               ($urandom_range(0, 3) != 0),
                               12'($urandom));
        end

        // Degenerate configuration: single 8-bit bus behaves as bitwise NOT.
        applyStimulusWide("wide_nom", 1'b1, 8'b10100101);
        checkOutput("wide_const", {24'd0, b_out_bus}, {24'd0, 8'b01011010});
        applyStimulusWide("wide_hold", 1'b0, 8'hFF);
        applyStimulusWide("wide_ones", 1'b1, 8'hFF);
        applyStimulusWide("wide_zero", 1'b1, 8'h00);
        for (int n = 0; n < 10; n++) begin
            applyStimulusWide("wide_rand", ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        if (a_queue.size() != 0 || b_queue.size() != 0) begin
            checkOutput("queue_empty", 32'(a_queue.size() + b_queue.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
